// File: rtl/regs_wb_sched.sv
// regs_wb_sched: write-port scheduler and busy-register scoreboard for the
// 31x32 integer register file (x0 hardwired to zero, single write port).
// EXE and LSU writebacks share the write port through a valid/ready arbiter.
// Decode issue is stalled on RAW/WAW hazards against outstanding destinations.
// Build option: define REGS_WB_RR_ARB_EN for round-robin arbitration between
// EXE and LSU; otherwise fixed priority with LSU winning ties.
module regs_wb_sched #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iss_valid,
  input  logic [AW-1:0]        iss_rs1_addr,
  input  logic [AW-1:0]        iss_rs2_addr,
  input  logic                 iss_rd_wen,
  input  logic [AW-1:0]        iss_rd_addr,
  output logic                 iss_ready,
  input  logic                 exe_valid,
  input  logic [AW-1:0]        exe_rd_addr,
  input  logic [XLEN-1:0]      exe_rd_data,
  output logic                 exe_ready,
  input  logic                 lsu_valid,
  input  logic [AW-1:0]        lsu_rd_addr,
  input  logic [XLEN-1:0]      lsu_rd_data,
  output logic                 lsu_ready,
  output logic                 rf_wen,
  output logic [AW-1:0]        rf_waddr,
  output logic [XLEN-1:0]      rf_wdata,
  output logic [(2**AW)-1:0]   busy_o,
  output logic [AW:0]          pend_cnt
);

  localparam int NREG = 2**AW;

  logic [NREG-1:0] busy;
  logic            exe_gnt;
  logic            lsu_gnt;
  logic [AW-1:0]   gnt_addr;
  logic [XLEN-1:0] gnt_data;
  logic            busy_set;
  logic            busy_clr;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;

  assign busy_o    = busy;
  assign exe_ready = exe_gnt;
  assign lsu_ready = lsu_gnt;

  // Hazard check: stall on any busy source, or a busy destination when writing.
  // Bit 0 of busy is never set, so x0 always reads not-busy.
  always_comb begin
    iss_ready = !(busy[iss_rs1_addr] | busy[iss_rs2_addr] |
                  (iss_rd_wen & busy[iss_rd_addr]));
  end

`ifdef REGS_WB_RR_ARB_EN
  localparam logic GNT_EXE = 1'b0;
  localparam logic GNT_LSU = 1'b1;

  logic last_grant;

  // Round-robin: on a tie, grant whichever source was not granted last.
  always_comb begin
    exe_gnt = exe_valid & (!lsu_valid | (last_grant == GNT_LSU));
    lsu_gnt = lsu_valid & !exe_gnt;
  end

  // Remember the most recent grant; idle cycles leave it unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= GNT_LSU;
    end else if (exe_gnt) begin
      last_grant <= GNT_EXE;
    end else if (lsu_gnt) begin
      last_grant <= GNT_LSU;
    end
  end
`else
  // Fixed priority: LSU always wins a tie.
  always_comb begin
    lsu_gnt = lsu_valid;
    exe_gnt = exe_valid & !lsu_valid;
  end
`endif

  // Mux the granted source onto the write path.
  always_comb begin
    gnt_addr = lsu_gnt ? lsu_rd_addr : exe_rd_addr;
    gnt_data = lsu_gnt ? lsu_rd_data : exe_rd_data;
  end

  // Register the write port; an x0 grant is consumed but never writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (exe_gnt | lsu_gnt) begin
      rf_wen   <= (gnt_addr != '0);
      rf_waddr <= gnt_addr;
      rf_wdata <= gnt_data;
    end else begin
      rf_wen   <= 1'b0;
    end
  end

  // Scoreboard set on issue, clear when the registered write retires.
  // A write to a register that is not busy leaves the scoreboard untouched.
  always_comb begin
    busy_set = iss_valid & iss_ready & iss_rd_wen & (iss_rd_addr != '0);
    busy_clr = rf_wen & busy[rf_waddr];
    set_mask = busy_set ? (NREG'(1) << iss_rd_addr) : '0;
    clr_mask = busy_clr ? (NREG'(1) << rf_waddr) : '0;
  end

  // Busy vector update; bit 0 is kept clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= ((busy | set_mask) & ~clr_mask) & ~NREG'(1);
    end
  end

  // Outstanding-destination count tracks the busy vector population.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_cnt <= '0;
    end else begin
      case ({busy_set, busy_clr})
        2'b10:   pend_cnt <= pend_cnt + (AW+1)'(1);
        2'b01:   pend_cnt <= pend_cnt - (AW+1)'(1);
        default: pend_cnt <= pend_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_regs_wb_sched.sv
// Directed testbench for regs_wb_sched: reset, RAW/WAW stalls, arbitration
// ties, x0 writes, scoreboard fill and drain, and asynchronous mid-run reset.
module tb_regs_wb_sched;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic            clk;
  logic            rst;
  logic            iss_valid;
  logic [AW-1:0]   iss_rs1_addr;
  logic [AW-1:0]   iss_rs2_addr;
  logic            iss_rd_wen;
  logic [AW-1:0]   iss_rd_addr;
  logic            iss_ready;
  logic            exe_valid;
  logic [AW-1:0]   exe_rd_addr;
  logic [XLEN-1:0] exe_rd_data;
  logic            exe_ready;
  logic            lsu_valid;
  logic [AW-1:0]   lsu_rd_addr;
  logic [XLEN-1:0] lsu_rd_data;
  logic            lsu_ready;
  logic            rf_wen;
  logic [AW-1:0]   rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic [31:0]     busy_o;
  logic [AW:0]     pend_cnt;

  int unsigned n_checks;
  int unsigned n_fail;

  regs_wb_sched #(.XLEN(XLEN), .AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .iss_valid    (iss_valid),
    .iss_rs1_addr (iss_rs1_addr),
    .iss_rs2_addr (iss_rs2_addr),
    .iss_rd_wen   (iss_rd_wen),
    .iss_rd_addr  (iss_rd_addr),
    .iss_ready    (iss_ready),
    .exe_valid    (exe_valid),
    .exe_rd_addr  (exe_rd_addr),
    .exe_rd_data  (exe_rd_data),
    .exe_ready    (exe_ready),
    .lsu_valid    (lsu_valid),
    .lsu_rd_addr  (lsu_rd_addr),
    .lsu_rd_data  (lsu_rd_data),
    .lsu_ready    (lsu_ready),
    .rf_wen       (rf_wen),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .busy_o       (busy_o),
    .pend_cnt     (pend_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                       input logic wen, input logic [AW-1:0] rd);
    iss_valid    = 1'b1;
    iss_rs1_addr = rs1;
    iss_rs2_addr = rs2;
    iss_rd_wen   = wen;
    iss_rd_addr  = rd;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0;
    iss_valid = 1'b0; iss_rs1_addr = '0; iss_rs2_addr = '0;
    iss_rd_wen = 1'b0; iss_rd_addr = '0;
    exe_valid = 1'b0; exe_rd_addr = '0; exe_rd_data = '0;
    lsu_valid = 1'b0; lsu_rd_addr = '0; lsu_rd_data = '0;
    #1 rst = 1'b1;
    tick();
    tick();
    check("rst_busy", 64'(busy_o), 64'h0);
    check("rst_pend", 64'(pend_cnt), 64'h0);
    check("rst_wen", 64'(rf_wen), 64'h0);
    check("rst_waddr", 64'(rf_waddr), 64'h0);
    check("rst_wdata", 64'(rf_wdata), 64'h0);
    rst = 1'b0;
    tick();

    // RAW: issue rd=x5, then a reader of x5 stalls until the write retires.
    issue(5'd0, 5'd0, 1'b1, 5'd5);
    #1 check("raw_issue_ready", 64'(iss_ready), 64'h1);
    tick();
    issue(5'd5, 5'd0, 1'b0, 5'd0);
    #1 check("raw_stall", 64'(iss_ready), 64'h0);
    check("raw_busy", 64'(busy_o), 64'h20);
    check("raw_pend1", 64'(pend_cnt), 64'h1);
    exe_valid = 1'b1; exe_rd_addr = 5'd5; exe_rd_data = 32'hDEADBEEF;
    #1 check("raw_exe_ready", 64'(exe_ready), 64'h1);
    tick();
    exe_valid = 1'b0;
    check("raw_wen", 64'(rf_wen), 64'h1);
    check("raw_waddr", 64'(rf_waddr), 64'h5);
    check("raw_wdata", 64'(rf_wdata), 64'hDEADBEEF);
    check("raw_stall_n1", 64'(iss_ready), 64'h0);
    check("raw_pend_n1", 64'(pend_cnt), 64'h1);
    tick();
    check("raw_wen_n2", 64'(rf_wen), 64'h0);
    check("raw_ready_n2", 64'(iss_ready), 64'h1);
    check("raw_pend0", 64'(pend_cnt), 64'h0);
    check("raw_busy0", 64'(busy_o), 64'h0);
    iss_valid = 1'b0;
    tick();

    // x0 writeback: accepted, never written, no scoreboard change.
    lsu_valid = 1'b1; lsu_rd_addr = 5'd0; lsu_rd_data = 32'h1234;
    #1 check("x0_lsu_ready", 64'(lsu_ready), 64'h1);
    tick();
    lsu_valid = 1'b0;
    check("x0_wen", 64'(rf_wen), 64'h0);
    check("x0_busy", 64'(busy_o), 64'h0);
    check("x0_pend", 64'(pend_cnt), 64'h0);
    tick();

    // WAW: x7 busy blocks a writer of x7 but not a non-writer.
    issue(5'd0, 5'd0, 1'b1, 5'd7);
    tick();
    check("waw_busy", 64'(busy_o), 64'h80);
    check("waw_stall", 64'(iss_ready), 64'h0);
    iss_rd_wen = 1'b0;
    #1 check("waw_nowen_ready", 64'(iss_ready), 64'h1);
    iss_rs2_addr = 5'd7;
    #1 check("waw_rs2_stall", 64'(iss_ready), 64'h0);
    iss_valid = 1'b0;
    tick();

    // Tie between EXE (x3) and LSU (x4).
    issue(5'd0, 5'd0, 1'b1, 5'd3);
    tick();
    issue(5'd0, 5'd0, 1'b1, 5'd4);
    tick();
    iss_valid = 1'b0;
    check("tie_busy", 64'(busy_o), 64'h98);
    check("tie_pend", 64'(pend_cnt), 64'h3);
    exe_valid = 1'b1; exe_rd_addr = 5'd3; exe_rd_data = 32'hAAAA0003;
    lsu_valid = 1'b1; lsu_rd_addr = 5'd4; lsu_rd_data = 32'hBBBB0004;
`ifdef REGS_WB_RR_ARB_EN
    #1 check("tie_exe_first", 64'(exe_ready), 64'h1);
    check("tie_lsu_wait", 64'(lsu_ready), 64'h0);
    tick();
    exe_valid = 1'b0;
    check("tie_waddr1", 64'(rf_waddr), 64'h3);
    check("tie_wdata1", 64'(rf_wdata), 64'hAAAA0003);
    #1 check("tie_lsu_next", 64'(lsu_ready), 64'h1);
    tick();
    lsu_valid = 1'b0;
    check("tie_waddr2", 64'(rf_waddr), 64'h4);
    check("tie_wdata2", 64'(rf_wdata), 64'hBBBB0004);
    check("tie_busy_mid", 64'(busy_o), 64'h90);
`else
    #1 check("tie_lsu_first", 64'(lsu_ready), 64'h1);
    check("tie_exe_wait", 64'(exe_ready), 64'h0);
    tick();
    lsu_valid = 1'b0;
    check("tie_waddr1", 64'(rf_waddr), 64'h4);
    check("tie_wdata1", 64'(rf_wdata), 64'hBBBB0004);
    #1 check("tie_exe_next", 64'(exe_ready), 64'h1);
    tick();
    exe_valid = 1'b0;
    check("tie_waddr2", 64'(rf_waddr), 64'h3);
    check("tie_wdata2", 64'(rf_wdata), 64'hAAAA0003);
    check("tie_busy_mid", 64'(busy_o), 64'h88);
`endif
    check("tie_wen2", 64'(rf_wen), 64'h1);
    tick();
    check("tie_busy_end", 64'(busy_o), 64'h80);
    check("tie_pend_end", 64'(pend_cnt), 64'h1);

    // Retire x7.
    exe_valid = 1'b1; exe_rd_addr = 5'd7; exe_rd_data = 32'h7;
    tick();
    exe_valid = 1'b0;
    tick();
    check("x7_busy0", 64'(busy_o), 64'h0);
    check("x7_pend0", 64'(pend_cnt), 64'h0);

    // Fill x1..x31.
    for (int i = 1; i < 32; i++) begin
      issue(5'd0, 5'd0, 1'b1, 5'(i));
      #1 check("fill_ready", 64'(iss_ready), 64'h1);
      tick();
    end
    iss_valid = 1'b0;
    check("fill_pend", 64'(pend_cnt), 64'd31);
    check("fill_busy", 64'(busy_o), 64'hFFFFFFFE);
    issue(5'd0, 5'd0, 1'b1, 5'd31);
    #1 check("fill_waw31", 64'(iss_ready), 64'h0);
    iss_valid = 1'b0;

    // Drain with alternating EXE/LSU.
    for (int i = 1; i < 32; i++) begin
      if (i % 2 == 1) begin
        exe_valid = 1'b1; exe_rd_addr = 5'(i); exe_rd_data = 32'(i) + 32'h100;
        lsu_valid = 1'b0;
      end else begin
        lsu_valid = 1'b1; lsu_rd_addr = 5'(i); lsu_rd_data = 32'(i) + 32'h200;
        exe_valid = 1'b0;
      end
      tick();
    end
    exe_valid = 1'b0;
    lsu_valid = 1'b0;
    check("drain_last_addr", 64'(rf_waddr), 64'd31);
    check("drain_last_data", 64'(rf_wdata), 64'h11F);
    check("drain_pend1", 64'(pend_cnt), 64'h1);
    tick();
    check("drain_pend0", 64'(pend_cnt), 64'h0);
    check("drain_busy0", 64'(busy_o), 64'h0);

    // Asynchronous reset mid-stream with x5 busy and a write in flight.
    issue(5'd0, 5'd0, 1'b1, 5'd5);
    tick();
    iss_valid = 1'b0;
    exe_valid = 1'b1; exe_rd_addr = 5'd5; exe_rd_data = 32'h55;
    tick();
    exe_valid = 1'b0;
    check("mid_busy", 64'(busy_o), 64'h20);
    check("mid_wen", 64'(rf_wen), 64'h1);
    rst = 1'b1;
    #1;
    check("arst_busy", 64'(busy_o), 64'h0);
    check("arst_pend", 64'(pend_cnt), 64'h0);
    check("arst_wen", 64'(rf_wen), 64'h0);
    tick();
    rst = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
